// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C initiator and its bench.
// The address-retry option is enabled with I2C_MASTER_ADDR_RETRY_EN.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int RETRY_MAX = 3;

    localparam logic [6:0] TARGET_ADDR = 7'b1010111;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period divider: pulses qtick every CLK_DIV cycles while enabled and
// advances the 2-bit bit-cell phase on each tick.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] phase
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign qtick = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            phase <= Q0;
        end else if (clr) begin
            count <= '0;
            phase <= Q0;
        end else if (qtick) begin
            count <= '0;
            phase <= phase + 2'd1;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address+RW, ACK, one data byte, ACK/NACK, STOP.
// Define I2C_MASTER_ADDR_RETRY_EN to retry a NACKed address up to RETRY_MAX attempts.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] addr_q, addr_n;
    logic       rw_q, rw_n;
    logic [7:0] data_q, data_n;
    logic       nack, nack_n;
    logic       err_pend, err_n;
    logic [7:0] data_rd_n;
    logic       busy_n, done_n, ack_err_n;
    logic       clr, qtick, sda_oe;
    logic [1:0] phase;
    logic       sample, end_cell;
    logic [7:0] addr_byte;
`ifdef I2C_MASTER_ADDR_RETRY_EN
    logic [1:0] attempt, attempt_n;
    logic       retry, retry_n;
`endif

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (busy),
        .qtick (qtick),
        .phase (phase)
    );

    assign sample    = qtick && (phase == Q2);
    assign end_cell  = qtick && (phase == Q3);
    assign addr_byte = {addr_q, rw_q};
    assign sda       = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            data_q   <= '0;
            nack     <= 1'b0;
            err_pend <= 1'b0;
            data_rd  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
`ifdef I2C_MASTER_ADDR_RETRY_EN
            attempt  <= '0;
            retry    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            addr_q   <= addr_n;
            rw_q     <= rw_n;
            data_q   <= data_n;
            nack     <= nack_n;
            err_pend <= err_n;
            data_rd  <= data_rd_n;
            busy     <= busy_n;
            done     <= done_n;
            ack_err  <= ack_err_n;
`ifdef I2C_MASTER_ADDR_RETRY_EN
            attempt  <= attempt_n;
            retry    <= retry_n;
`endif
        end
    end

    // SCL is low in Q0/Q1 and high in Q2/Q3 of every bit cell; SDA only moves at Q0.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        addr_n    = addr_q;
        rw_n      = rw_q;
        data_n    = data_q;
        nack_n    = nack;
        err_n     = err_pend;
        data_rd_n = data_rd;
        busy_n    = busy;
        done_n    = 1'b0;
        ack_err_n = ack_err;
        clr       = 1'b0;
        scl       = 1'b1;
        sda_oe    = 1'b0;
`ifdef I2C_MASTER_ADDR_RETRY_EN
        attempt_n = attempt;
        retry_n   = retry;
`endif
        case (state)
            IDLE: begin
                if (busy) begin
                    busy_n = 1'b0;
                end else if (start) begin
                    addr_n    = addr;
                    rw_n      = rw;
                    data_n    = data_wr;
                    ack_err_n = 1'b0;
                    err_n     = 1'b0;
                    busy_n    = 1'b1;
                    clr       = 1'b1;
                    state_n   = START;
`ifdef I2C_MASTER_ADDR_RETRY_EN
                    attempt_n = '0;
                    retry_n   = 1'b0;
`endif
                end
            end
            START: begin
                sda_oe = phase[1];
                if (end_cell) begin
                    state_n   = ADDR;
                    bit_cnt_n = 3'd7;
                end
            end
            ADDR: begin
                scl    = phase[1];
                sda_oe = !addr_byte[bit_cnt];
                if (end_cell) begin
                    if (bit_cnt == 3'd0) state_n = ACK1;
                    else                 bit_cnt_n = bit_cnt - 3'd1;
                end
            end
            ACK1: begin
                scl = phase[1];
                if (sample) begin
                    nack_n = 1'b1;
                    if (sda == 1'b0) nack_n = 1'b0;
                end
                if (end_cell) begin
                    if (nack) begin
                        state_n = STOP;
`ifdef I2C_MASTER_ADDR_RETRY_EN
                        if (attempt != 2'(RETRY_MAX - 1)) retry_n = 1'b1;
                        else                              err_n   = 1'b1;
`else
                        err_n = 1'b1;
`endif
                    end else begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd7;
                    end
                end
            end
            DATA: begin
                scl    = phase[1];
                sda_oe = !rw_q && !data_q[bit_cnt];
                if (sample && rw_q) begin
                    data_rd_n = {data_rd[6:0], 1'b1};
                    if (sda == 1'b0) data_rd_n[0] = 1'b0;
                end
                if (end_cell) begin
                    if (bit_cnt == 3'd0) state_n = ACK2;
                    else                 bit_cnt_n = bit_cnt - 3'd1;
                end
            end
            ACK2: begin
                scl = phase[1];
                if (sample) begin
                    nack_n = 1'b1;
                    if (sda == 1'b0) nack_n = 1'b0;
                end
                if (end_cell) begin
                    if (!rw_q && nack) err_n = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                scl    = phase[1];
                sda_oe = (phase != Q3);
                if (end_cell) begin
`ifdef I2C_MASTER_ADDR_RETRY_EN
                    if (retry) begin
                        retry_n   = 1'b0;
                        attempt_n = attempt + 2'd1;
                        state_n   = START;
                    end else begin
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        ack_err_n = err_pend;
                    end
`else
                    state_n   = IDLE;
                    done_n    = 1'b1;
                    ack_err_n = err_pend;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural target at TARGET_ADDR and an SDA pull-up.
// Expectations follow I2C_MASTER_ADDR_RETRY_EN when it is defined.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int LAT_FULL = 80 * CLK_DIV + 1;
`ifdef I2C_MASTER_ADDR_RETRY_EN
    localparam int NACK_FRAMES = RETRY_MAX;
`else
    localparam int NACK_FRAMES = 1;
`endif
    localparam int LAT_NACK = NACK_FRAMES * 44 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] data_wr = '0;
    logic [7:0] data_rd;
    logic       busy, done, ack_err, scl;
    wire        sda;
    logic       tgt_oe = 1'b0;

    pullup (sda);
    assign sda = tgt_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .data_wr (data_wr),
        .data_rd (data_rd),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat = 0;
    int stops_before = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {T_IDLE, T_ADDR, T_ACK_A, T_DATA_R, T_DATA_W, T_ACK_D} tphase_t;
    tphase_t    tph = T_IDLE;
    logic       p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0, t_rw = 1'b0;
    logic [7:0] shreg = '0, wr_byte = '0, rd_byte = 8'hCD;
    int         bit_i = 0, rises = 0, last_rises = 0, stops = 0, viol = 0;

    // Bus monitor and target model, sampled mid-cycle so SCL/SDA are settled.
    // The target drives only on SCL falling edges and samples on SCL rising edges.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_scl = 1'b1; p_sda = 1'b1; in_frame = 1'b0;
                tgt_oe = 1'b0; tph = T_IDLE;
            end else begin
                if (p_scl && scl && (sda !== p_sda)) begin
                    if (!sda && !in_frame) begin
                        in_frame = 1'b1; rises = 0; tph = T_ADDR; bit_i = 0; shreg = '0;
                    end else if (sda && in_frame) begin
                        // The final SCL rise belongs to the STOP condition, not a bit cell.
                        in_frame = 1'b0; last_rises = rises - 1; stops++;
                        tph = T_IDLE; tgt_oe = 1'b0;
                    end else begin
                        viol++;
                        $display("[TB] protocol violation: SDA moved with SCL high at cycle %0d", cyc);
                    end
                end else if (!p_scl && scl && in_frame) begin
                    rises++;
                    if (tph == T_ADDR || tph == T_DATA_W) begin
                        shreg = {shreg[6:0], sda};
                        bit_i++;
                    end else if (tph == T_DATA_R) begin
                        bit_i++;
                    end
                end else if (p_scl && !scl && in_frame) begin
                    case (tph)
                        T_ADDR: if (bit_i == 8) begin
                            if (shreg[7:1] == TARGET_ADDR) begin
                                tgt_oe = 1'b1; t_rw = shreg[0]; tph = T_ACK_A;
                            end else begin
                                tph = T_IDLE;
                            end
                        end
                        T_ACK_A: begin
                            bit_i = 0;
                            if (t_rw) begin
                                tph = T_DATA_R; tgt_oe = !rd_byte[7];
                            end else begin
                                tph = T_DATA_W; shreg = '0; tgt_oe = 1'b0;
                            end
                        end
                        T_DATA_R: begin
                            if (bit_i == 8) begin
                                tgt_oe = 1'b0; tph = T_IDLE;
                            end else begin
                                tgt_oe = !rd_byte[7 - bit_i];
                            end
                        end
                        T_DATA_W: if (bit_i == 8) begin
                            wr_byte = shreg; tgt_oe = 1'b1; tph = T_ACK_D;
                        end
                        T_ACK_D: begin
                            tgt_oe = 1'b0; tph = T_IDLE;
                        end
                        default: ;
                    endcase
                end
                p_scl = scl;
                p_sda = sda;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] d);
        @(posedge clk);
        #1;
        addr = a; rw = r; data_wr = d; start = 1'b1;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_done_seen"}, done, 1'b1);
        lat = cyc - acc_cyc;
    endtask

    initial begin
        $display("[TB] starting i2c_master bench");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_scl", scl, 1'b1);
        checkOutput("rst_sda", sda, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ack_err", ack_err, 1'b0);
        checkOutput("rst_data_rd", data_rd, 8'h00);
        rst_n = 1'b1;

        // Read from the target
        applyStimulus(7'h57, 1'b1, 8'h00);
        checkOutput("rd_busy_after_accept", busy, 1'b1);
        waitDone("rd");
        checkOutput("rd_latency", lat, LAT_FULL);
        checkOutput("rd_busy_in_done", busy, 1'b1);
        checkOutput("rd_ack_err", ack_err, 1'b0);
        checkOutput("rd_data", data_rd, 8'hCD);
        checkOutput("rd_scl_rises", last_rises, 18);
        @(posedge clk);
        #1;
        checkOutput("rd_busy_after_done", busy, 1'b0);
        checkOutput("rd_done_pulse", done, 1'b0);

        // Write with a stray start mid-transfer and changed operands
        applyStimulus(7'h57, 1'b0, 8'hA5);
        repeat (50) @(posedge clk);
        #1;
        addr = 7'h22; rw = 1'b1; data_wr = 8'h3C; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("wr_busy_mid", busy, 1'b1);
        waitDone("wr");
        checkOutput("wr_latency", lat, LAT_FULL);
        checkOutput("wr_ack_err", ack_err, 1'b0);
        checkOutput("wr_target_byte", wr_byte, 8'hA5);
        checkOutput("wr_scl_rises", last_rises, 18);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("wr_stray_start_ignored", busy, 1'b0);

        // Address NACK, then start held through the done cycle
        stops_before = stops;
        applyStimulus(7'h22, 1'b0, 8'h55);
        waitDone("nack");
        checkOutput("nack_latency", lat, LAT_NACK);
        checkOutput("nack_ack_err", ack_err, 1'b1);
        checkOutput("nack_scl_rises", last_rises, 9);
        checkOutput("nack_frames", stops - stops_before, NACK_FRAMES);
        checkOutput("nack_data_rd_kept", data_rd, 8'hCD);
        addr = 7'h57; rw = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("done_cycle_start_ignored", busy, 1'b0);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("next_cycle_accept", busy, 1'b1);
        checkOutput("ack_err_cleared", ack_err, 1'b0);
        waitDone("rd2");
        checkOutput("rd2_latency", lat, LAT_FULL);
        checkOutput("rd2_data", data_rd, 8'hCD);

        // Reset during address bit 3, then a clean read
        repeat (2) @(posedge clk);
        applyStimulus(7'h57, 1'b1, 8'h00);
        repeat (87) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_scl", scl, 1'b1);
        checkOutput("abort_sda", sda, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_data_rd", data_rd, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(7'h57, 1'b1, 8'h00);
        waitDone("rd3");
        checkOutput("rd3_latency", lat, LAT_FULL);
        checkOutput("rd3_ack_err", ack_err, 1'b0);
        checkOutput("rd3_data", data_rd, 8'hCD);
        checkOutput("rd3_scl_rises", last_rises, 18);

        repeat (5) @(posedge clk);
        checkOutput("protocol_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
